// File: rtl/decode_stage.sv
`timescale 1ns/1ps
// RV32I decode: regfile, immediate generator, control decode; 1-cycle ID/EX register, enable=0 holds, clr_ex loads a bubble.
// Optional WB_BYPASS_EN: a same-edge write-back to a source register is returned write-first into rd1/rd2.
module decode_stage #(
    parameter int          NUM_REGS = 32,
    parameter logic [31:0] SP_INIT  = 32'h0
) (
    input  logic        clk_de,
    input  logic        rst_n_de,
    input  logic        enable,
    input  logic        clr_ex,
    input  logic [31:0] instr,
    input  logic [31:0] pc_de,
    input  logic [31:0] pc_next_de,
    input  logic        we_wb,
    input  logic [4:0]  rd_wb,
    input  logic [31:0] wd_wb,
    output logic [4:0]  rs1_de,
    output logic [4:0]  rs2_de,
    output logic [31:0] rd1_ex,
    output logic [31:0] rd2_ex,
    output logic [31:0] imm_ex,
    output logic [31:0] pc_ex,
    output logic [31:0] pc_next_ex,
    output logic [4:0]  rs1_ex,
    output logic [4:0]  rs2_ex,
    output logic [4:0]  rd_ex,
    output logic        reg_write_ex,
    output logic        mem_write_ex,
    output logic        jump_ex,
    output logic        branch_ex,
    output logic        alu_src_ex,
    output logic        alu_a_pc_ex,
    output logic        illegal_ex,
    output logic [1:0]  result_src_ex,
    output logic [3:0]  alu_ctrl_ex,
    output logic [2:0]  funct3_ex
);
    localparam int AW    = $clog2(NUM_REGS);
    localparam bit RV32E = (NUM_REGS == 16);

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;

    localparam logic [3:0] ALU_ADD = 4'h0, ALU_SUB = 4'h1, ALU_AND = 4'h2, ALU_OR  = 4'h3;
    localparam logic [3:0] ALU_XOR = 4'h4, ALU_SLT = 4'h5, ALU_SLTU = 4'h6, ALU_SLL = 4'h7;
    localparam logic [3:0] ALU_SRL = 4'h8, ALU_SRA = 4'h9, ALU_PASSB = 4'hA;

    typedef struct packed {
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic [31:0] imm;
        logic [31:0] pc;
        logic [31:0] pc_next;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic        reg_write;
        logic        mem_write;
        logic        jump;
        logic        branch;
        logic        alu_src;
        logic        alu_a_pc;
        logic        illegal;
        logic [1:0]  result_src;
        logic [3:0]  alu_ctrl;
        logic [2:0]  funct3;
    } idex_t;

    logic [31:0] r_rf [NUM_REGS];
    idex_t       r_idex;
    idex_t       w_dec;

    logic [6:0]  w_op;
    logic [6:0]  w_f7;
    logic [2:0]  w_f3;
    logic [4:0]  w_rs1, w_rs2, w_rd;
    logic [31:0] w_rd1, w_rd2;
    logic [31:0] w_imm_i, w_imm_s, w_imm_b, w_imm_u, w_imm_j;
    logic [3:0]  w_alu_base;
    logic        w_wr_ok, w_known, w_f7_ok, w_ill_idx, w_illegal;

    assign w_op   = instr[6:0];
    assign w_rd   = instr[11:7];
    assign w_f3   = instr[14:12];
    assign w_rs1  = instr[19:15];
    assign w_rs2  = instr[24:20];
    assign w_f7   = instr[31:25];
    assign rs1_de = w_rs1;
    assign rs2_de = w_rs2;

    assign w_imm_i = {{20{instr[31]}}, instr[31:20]};
    assign w_imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    assign w_imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    assign w_imm_u = {instr[31:12], 12'b0};
    assign w_imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

    assign w_wr_ok = we_wb && (rd_wb != 5'd0) && (!RV32E || !rd_wb[4]);

    always_ff @(posedge clk_de or negedge rst_n_de) begin
        if (!rst_n_de) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_rf[i] <= (i == 2) ? SP_INIT : 32'h0;
            end
        end else if (w_wr_ok) begin
            r_rf[rd_wb[AW-1:0]] <= wd_wb;
        end
    end

    always_comb begin
        w_rd1 = (w_rs1 == 5'd0) ? 32'h0 : r_rf[w_rs1[AW-1:0]];
        w_rd2 = (w_rs2 == 5'd0) ? 32'h0 : r_rf[w_rs2[AW-1:0]];
`ifdef WB_BYPASS_EN
        if (w_wr_ok && (rd_wb == w_rs1)) w_rd1 = wd_wb;
        if (w_wr_ok && (rd_wb == w_rs2)) w_rd2 = wd_wb;
`endif
    end

    // SUB exists only as an R-type op; SRA/SRAI are selected by instr[30] on funct3=101.
    always_comb begin
        w_alu_base = ALU_ADD;
        case (w_f3)
            3'b000:  w_alu_base = (w_op == OP_R && instr[30]) ? ALU_SUB : ALU_ADD;
            3'b001:  w_alu_base = ALU_SLL;
            3'b010:  w_alu_base = ALU_SLT;
            3'b011:  w_alu_base = ALU_SLTU;
            3'b100:  w_alu_base = ALU_XOR;
            3'b101:  w_alu_base = instr[30] ? ALU_SRA : ALU_SRL;
            3'b110:  w_alu_base = ALU_OR;
            default: w_alu_base = ALU_AND;
        endcase
    end

    assign w_known   = w_op inside {OP_R, OP_I, OP_LOAD, OP_STORE, OP_BR, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC};
    assign w_f7_ok   = (w_f7 == 7'h00) || ((w_f7 == 7'h20) && ((w_f3 == 3'b000) || (w_f3 == 3'b101)));
    assign w_ill_idx = RV32E && (w_rs1[4] || w_rs2[4] || w_rd[4]);
    assign w_illegal = !w_known || ((w_op == OP_R) && !w_f7_ok) || w_ill_idx;

    always_comb begin
        w_dec         = '0;
        w_dec.rd1     = w_rd1;
        w_dec.rd2     = w_rd2;
        w_dec.pc      = pc_de;
        w_dec.pc_next = pc_next_de;
        w_dec.rs1     = w_rs1;
        w_dec.rs2     = w_rs2;
        w_dec.rd      = w_rd;
        w_dec.funct3  = w_f3;
        if (w_illegal) begin
            w_dec.illegal = 1'b1;
        end else begin
            case (w_op)
                OP_R: begin
                    w_dec.reg_write = 1'b1;
                    w_dec.alu_ctrl  = w_alu_base;
                end
                OP_I: begin
                    w_dec.reg_write = 1'b1;
                    w_dec.alu_src   = 1'b1;
                    w_dec.imm       = w_imm_i;
                    w_dec.alu_ctrl  = w_alu_base;
                end
                OP_LOAD: begin
                    w_dec.reg_write  = 1'b1;
                    w_dec.alu_src    = 1'b1;
                    w_dec.imm        = w_imm_i;
                    w_dec.result_src = 2'b01;
                end
                OP_STORE: begin
                    w_dec.mem_write = 1'b1;
                    w_dec.alu_src   = 1'b1;
                    w_dec.imm       = w_imm_s;
                end
                OP_BR: begin
                    w_dec.branch   = 1'b1;
                    w_dec.imm      = w_imm_b;
                    w_dec.alu_ctrl = ALU_SUB;
                end
                OP_JAL: begin
                    w_dec.reg_write  = 1'b1;
                    w_dec.jump       = 1'b1;
                    w_dec.alu_src    = 1'b1;
                    w_dec.alu_a_pc   = 1'b1;
                    w_dec.imm        = w_imm_j;
                    w_dec.result_src = 2'b10;
                end
                OP_JALR: begin
                    w_dec.reg_write  = 1'b1;
                    w_dec.jump       = 1'b1;
                    w_dec.alu_src    = 1'b1;
                    w_dec.imm        = w_imm_i;
                    w_dec.result_src = 2'b10;
                end
                OP_LUI: begin
                    w_dec.reg_write = 1'b1;
                    w_dec.alu_src   = 1'b1;
                    w_dec.imm       = w_imm_u;
                    w_dec.alu_ctrl  = ALU_PASSB;
                end
                default: begin
                    w_dec.reg_write = 1'b1;
                    w_dec.alu_src   = 1'b1;
                    w_dec.alu_a_pc  = 1'b1;
                    w_dec.imm       = w_imm_u;
                end
            endcase
        end
    end

    // Flush wins over stall so a bubble can be injected while the stage is held.
    always_ff @(posedge clk_de or negedge rst_n_de) begin
        if (!rst_n_de) begin
            r_idex <= '0;
        end else if (clr_ex) begin
            r_idex <= '0;
        end else if (enable) begin
            r_idex <= w_dec;
        end
    end

    assign rd1_ex        = r_idex.rd1;
    assign rd2_ex        = r_idex.rd2;
    assign imm_ex        = r_idex.imm;
    assign pc_ex         = r_idex.pc;
    assign pc_next_ex    = r_idex.pc_next;
    assign rs1_ex        = r_idex.rs1;
    assign rs2_ex        = r_idex.rs2;
    assign rd_ex         = r_idex.rd;
    assign reg_write_ex  = r_idex.reg_write;
    assign mem_write_ex  = r_idex.mem_write;
    assign jump_ex       = r_idex.jump;
    assign branch_ex     = r_idex.branch;
    assign alu_src_ex    = r_idex.alu_src;
    assign alu_a_pc_ex   = r_idex.alu_a_pc;
    assign illegal_ex    = r_idex.illegal;
    assign result_src_ex = r_idex.result_src;
    assign alu_ctrl_ex   = r_idex.alu_ctrl;
    assign funct3_ex     = r_idex.funct3;
endmodule

// File: tb/tb_decode_stage.sv
`timescale 1ns/1ps
// Scoreboard bench for decode_stage: driver pushes expected ID/EX contents, monitor pops and compares after each edge.
module tb_decode_stage;
    localparam logic [31:0] SP = 32'h1000_0F00;

    logic        clk_de = 1'b0;
    logic        rst_n_de = 1'b1;
    logic        enable = 1'b0, clr_ex = 1'b0, we_wb = 1'b0;
    logic [31:0] instr = '0, pc_de = '0, pc_next_de = '0, wd_wb = '0;
    logic [4:0]  rd_wb = '0;
    logic [4:0]  rs1_de, rs2_de, rs1_ex, rs2_ex, rd_ex;
    logic [31:0] rd1_ex, rd2_ex, imm_ex, pc_ex, pc_next_ex;
    logic        reg_write_ex, mem_write_ex, jump_ex, branch_ex, alu_src_ex, alu_a_pc_ex, illegal_ex;
    logic [1:0]  result_src_ex;
    logic [3:0]  alu_ctrl_ex;
    logic [2:0]  funct3_ex;

    decode_stage #(.NUM_REGS(32), .SP_INIT(SP)) dut (
        .clk_de(clk_de), .rst_n_de(rst_n_de), .enable(enable), .clr_ex(clr_ex),
        .instr(instr), .pc_de(pc_de), .pc_next_de(pc_next_de),
        .we_wb(we_wb), .rd_wb(rd_wb), .wd_wb(wd_wb),
        .rs1_de(rs1_de), .rs2_de(rs2_de), .rd1_ex(rd1_ex), .rd2_ex(rd2_ex), .imm_ex(imm_ex),
        .pc_ex(pc_ex), .pc_next_ex(pc_next_ex), .rs1_ex(rs1_ex), .rs2_ex(rs2_ex), .rd_ex(rd_ex),
        .reg_write_ex(reg_write_ex), .mem_write_ex(mem_write_ex), .jump_ex(jump_ex),
        .branch_ex(branch_ex), .alu_src_ex(alu_src_ex), .alu_a_pc_ex(alu_a_pc_ex),
        .illegal_ex(illegal_ex), .result_src_ex(result_src_ex), .alu_ctrl_ex(alu_ctrl_ex),
        .funct3_ex(funct3_ex)
    );

    always #5 clk_de = ~clk_de;

    typedef struct packed {
        logic [31:0] rd1, rd2, imm, pc, pcn;
        logic [4:0]  rs1, rs2, rd;
        logic        rw, mw, j, b, as, ap, ill;
        logic [1:0]  rs;
        logic [3:0]  ac;
        logic [2:0]  f3;
    } out_t;

    typedef enum {C_R, C_I, C_LD, C_ST, C_BR, C_JAL, C_JALR, C_LUI, C_AUIPC, C_BAD} cls_t;

    out_t        act;
    out_t        q[$];
    out_t        cur;
    logic [31:0] mrf [32];
    int          alu_tab [8] = '{0, 7, 5, 6, 4, 8, 3, 2};
    int          checks = 0, errors = 0;

    assign act = {rd1_ex, rd2_ex, imm_ex, pc_ex, pc_next_ex, rs1_ex, rs2_ex, rd_ex,
                  reg_write_ex, mem_write_ex, jump_ex, branch_ex, alu_src_ex, alu_a_pc_ex,
                  illegal_ex, result_src_ex, alu_ctrl_ex, funct3_ex};

    function automatic void chk(string name, logic [191:0] a, logic [191:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, a, e);
        end
    endfunction

    function automatic logic [31:0] rdreg(logic [4:0] idx, bit we, logic [4:0] rd, logic [31:0] wd);
        if (idx == 5'd0) return 32'h0;
`ifdef WB_BYPASS_EN
        if (we && rd == idx) return wd;
`endif
        return mrf[idx];
    endfunction

    function automatic out_t model(logic [31:0] ins, logic [31:0] pc, logic [31:0] pcn,
                                   bit we, logic [4:0] rd, logic [31:0] wd);
        out_t o;
        cls_t c;
        int   sx;
        int   f3;
        o  = '0;
        sx = ins;
        f3 = int'(ins[14:12]);
        case (ins[6:0])
            7'h33: c = C_R;     7'h13: c = C_I;    7'h03: c = C_LD;
            7'h23: c = C_ST;    7'h63: c = C_BR;   7'h6F: c = C_JAL;
            7'h67: c = C_JALR;  7'h37: c = C_LUI;  7'h17: c = C_AUIPC;
            default: c = C_BAD;
        endcase
        if (c == C_R && !(ins[31:25] == 7'h00 || (ins[31:25] == 7'h20 && (f3 == 0 || f3 == 5))))
            c = C_BAD;
        o.rd1 = rdreg(ins[19:15], we, rd, wd);
        o.rd2 = rdreg(ins[24:20], we, rd, wd);
        o.pc  = pc;
        o.pcn = pcn;
        o.rs1 = ins[19:15];
        o.rs2 = ins[24:20];
        o.rd  = ins[11:7];
        o.f3  = ins[14:12];
        o.ill = (c == C_BAD);
        o.rw  = c inside {C_R, C_I, C_LD, C_JAL, C_JALR, C_LUI, C_AUIPC};
        o.mw  = (c == C_ST);
        o.j   = (c == C_JAL) || (c == C_JALR);
        o.b   = (c == C_BR);
        o.as  = c inside {C_I, C_LD, C_ST, C_JAL, C_JALR, C_LUI, C_AUIPC};
        o.ap  = (c == C_JAL) || (c == C_AUIPC);
        o.rs  = (c == C_LD) ? 2'd1 : o.j ? 2'd2 : 2'd0;
        case (c)
            C_I, C_LD, C_JALR: o.imm = 32'(sx >>> 20);
            C_ST:    o.imm = 32'((sx >>> 25) <<< 5) | 32'(ins[11:7]);
            C_BR:    o.imm = 32'((sx >>> 31) <<< 12) | (32'(ins[7]) << 11) | (32'(ins[30:25]) << 5) | (32'(ins[11:8]) << 1);
            C_LUI, C_AUIPC: o.imm = ins & 32'hFFFF_F000;
            C_JAL:   o.imm = 32'((sx >>> 31) <<< 20) | (32'(ins[19:12]) << 12) | (32'(ins[20]) << 11) | (32'(ins[30:21]) << 1);
            default: o.imm = 32'h0;
        endcase
        if (c == C_R || c == C_I) begin
            o.ac = 4'(alu_tab[f3]);
            if (f3 == 5 && ins[30]) o.ac = 4'd9;
            if (c == C_R && f3 == 0 && ins[30]) o.ac = 4'd1;
        end else if (c == C_BR) o.ac = 4'd1;
        else if (c == C_LUI)    o.ac = 4'd10;
        else                    o.ac = 4'd0;
        return o;
    endfunction

    task automatic step(input logic [31:0] ins, input bit en, input bit clr,
                        input bit we, input logic [4:0] rd, input logic [31:0] wd);
        logic [31:0] pc;
        @(negedge clk_de);
        pc = $urandom() & 32'hFFFF_FFFC;
        instr = ins; pc_de = pc; pc_next_de = pc + 32'd4;
        enable = en; clr_ex = clr; we_wb = we; rd_wb = rd; wd_wb = wd;
        if (clr)     cur = '0;
        else if (en) cur = model(ins, pc, pc + 32'd4, we, rd, wd);
        if (we && rd != 5'd0) mrf[rd] = wd;
        q.push_back(cur);
        #1 chk("rs_de", {rs1_de, rs2_de}, {ins[19:15], ins[24:20]});
    endtask

    task automatic settle();
        @(posedge clk_de);
        #3;
    endtask

    task automatic do_reset();
        @(posedge clk_de);
        #3;
        rst_n_de = 1'b0; enable = 1'b0; clr_ex = 1'b0; we_wb = 1'b0;
        #1 chk("reset_now", act, '0);
        for (int i = 0; i < 32; i++) mrf[i] = 32'h0;
        mrf[2] = SP;
        cur = '0;
        @(negedge clk_de);
        chk("reset_hold", act, '0);
        rst_n_de = 1'b1;
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] ins;
        int k;
        ins = $urandom();
        k = $urandom_range(0, 12);
        case (k)
            0: begin ins[6:0] = 7'h33; ins[31:25] = 7'h00; end
            1: begin ins[6:0] = 7'h33; ins[31:25] = 7'h20; end
            2: ins[6:0] = 7'h33;
            3: ins[6:0] = 7'h13;
            4: ins[6:0] = 7'h03;
            5: ins[6:0] = 7'h23;
            6: ins[6:0] = 7'h63;
            7: ins[6:0] = 7'h6F;
            8: ins[6:0] = 7'h67;
            9: ins[6:0] = 7'h37;
            10: ins[6:0] = 7'h17;
            11: ins = ($urandom_range(0, 1) == 0) ? 32'h0000_0073 : 32'h0000_000F;
            default: ;
        endcase
        return ins;
    endfunction

    always begin : monitor
        out_t e;
        @(posedge clk_de);
        #2;
        if (q.size() > 0) begin
            e = q.pop_front();
            chk("idex", act, e);
        end
    end

    initial begin
        do_reset();

        step(32'h0000_0013, 1, 0, 1, 5'd5, 32'hDEAD_BEEF);
        step(32'h0062_83B3, 1, 0, 0, 5'd0, 32'h0);
        settle();
        chk("add_rd1", rd1_ex, 32'hDEAD_BEEF);
        chk("add_alu", alu_ctrl_ex, 4'h0);
        chk("add_rw", reg_write_ex, 1'b1);

        step(32'h0001_00B3, 1, 0, 0, 5'd0, 32'h0);
        settle();
        chk("sp_init", rd1_ex, SP);

        step(32'hFE61_2E23, 1, 0, 0, 5'd0, 32'h0);
        settle();
        chk("sw_imm", imm_ex, 32'hFFFF_FFFC);
        chk("sw_ctl", {mem_write_ex, reg_write_ex, funct3_ex}, {1'b1, 1'b0, 3'b010});

        step(32'hFF9F_F0EF, 0, 0, 0, 5'd0, 32'h0);
        step(32'h0062_83B3, 0, 0, 0, 5'd0, 32'h0);
        settle();
        chk("stall_hold", {imm_ex, mem_write_ex}, {32'hFFFF_FFFC, 1'b1});
        step(32'hFF9F_F0EF, 0, 1, 0, 5'd0, 32'h0);
        settle();
        chk("flush", act, '0);

        step(32'h0062_83B3, 1, 0, 1, 5'd5, 32'h1234_5678);
        settle();
`ifdef WB_BYPASS_EN
        chk("same_edge_wb", rd1_ex, 32'h1234_5678);
`else
        chk("same_edge_wb", rd1_ex, 32'hDEAD_BEEF);
`endif
        step(32'h0050_03B3, 1, 0, 1, 5'd0, 32'hFFFF_FFFF);
        step(32'h0050_03B3, 1, 0, 0, 5'd0, 32'h0);
        settle();
        chk("x0_zero", {rd1_ex, rd2_ex}, {32'h0, 32'h1234_5678});

        step(32'hFF9F_F0EF, 1, 0, 0, 5'd0, 32'h0);
        settle();
        chk("jal_imm", imm_ex, 32'hFFFF_FFF8);
        chk("jal_ctl", {jump_ex, result_src_ex, rd_ex}, {1'b1, 2'b10, 5'd1});
        step(32'h0000_0073, 1, 0, 0, 5'd0, 32'h0);
        settle();
        chk("ecall_ill", {illegal_ex, reg_write_ex}, {1'b1, 1'b0});
        step(32'h0000_0000, 1, 0, 0, 5'd0, 32'h0);
        settle();
        chk("zero_ill", illegal_ex, 1'b1);

        for (int i = 0; i < 400; i++) begin
            if (i == 200) begin
                do_reset();
                step(32'h0022_83B3, 1, 0, 0, 5'd0, 32'h0);
                settle();
                chk("post_reset_regs", {rd1_ex, rd2_ex}, {32'h0, SP});
            end
            step(rand_instr(), $urandom_range(0, 9) != 0, $urandom_range(0, 9) == 0,
                 $urandom_range(0, 1) == 1, 5'($urandom_range(0, 31)), $urandom());
        end

        repeat (3) settle();
        chk("drain", q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
